// File: rtl/prog_fetch.sv
`default_nettype none
// ============================================================================
// Module   : prog_fetch
// Purpose  : Fetch unit. Owns the program counter that addresses the
//            instruction ROM, sequences IDLE -> RUN -> DONE under the Start
//            handshake, follows taken branches from the decoder and counts
//            RUN cycles (saturating) for performance reporting.
// Ports    : Clk        - clock, rising edge
//            Reset      - asynchronous active-low reset
//            Start      - launch (pulse high then low) / abort while running
//            BranchEn   - decoder: current instruction is a branch
//            CondFlag   - ALU flag: branch condition true
//            Ack        - decoder: current instruction is halt
//            TargetAddr - branch target, valid when BranchEn=1
//            ProgCtr    - instruction ROM address (registered)
//            Running    - high while in RUN (registered)
//            Done       - high while in DONE (registered)
//            CycleCnt   - RUN cycles of the current/last run
// Revision : 1.0 - initial release
// ============================================================================
module prog_fetch #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned START_PC = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic             CondFlag,
    input  logic             Ack,
    input  logic [PC_W-1:0]  TargetAddr,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam logic [PC_W-1:0]  C_START_ADDR = PC_W'(START_PC);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state,   state_nxt;
    logic             armed,   armed_nxt;
    logic [PC_W-1:0]  pc,      pc_nxt;
    logic [CNT_W-1:0] cnt,     cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             running, done;

    // Counter stops at all-ones instead of wrapping.
    assign cnt_inc = (cnt == C_CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            armed   <= 1'b0;
            pc      <= C_START_ADDR;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed   <= armed_nxt;
            pc      <= pc_nxt;
            cnt     <= cnt_nxt;
            // Status flags are registered from the next state so they
            // line up exactly with the state register.
            running <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        armed_nxt = armed;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                pc_nxt = C_START_ADDR;
                if (Start) begin
                    armed_nxt = 1'b1;
                end else if (armed) begin
                    // Falling side of the Start handshake launches the run.
                    state_nxt = RUN;
                    armed_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (Start) begin
                    // Abort: back to IDLE already armed, counter keeps value.
                    state_nxt = IDLE;
                    armed_nxt = 1'b1;
                    pc_nxt    = C_START_ADDR;
                end else if (Ack) begin
                    // Halt wins over branch; PC stays on the halt instruction.
                    state_nxt = DONE;
                    cnt_nxt   = cnt_inc;
                end else if (BranchEn && CondFlag) begin
                    pc_nxt  = TargetAddr;
                    cnt_nxt = cnt_inc;
                end else begin
                    pc_nxt  = pc + 1'b1;
                    cnt_nxt = cnt_inc;
                end
            end
            DONE: begin
                if (Start) begin
                    state_nxt = IDLE;
                    armed_nxt = 1'b1;
                    pc_nxt    = C_START_ADDR;
                end
            end
            default: begin
                state_nxt = IDLE;
                armed_nxt = 1'b0;
                pc_nxt    = C_START_ADDR;
            end
        endcase
    end

    assign ProgCtr  = pc;
    assign CycleCnt = cnt;
    assign Running  = running;
    assign Done     = done;

endmodule
`default_nettype wire

// File: tb/tb_prog_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_fetch
// Purpose  : Self-checking bench for prog_fetch. Directed stimulus pushes the
//            hand-computed expected outputs into per-DUT queues; independent
//            monitors pop and compare after each clock edge or async reset.
//            A second instance with PC_W=4, CNT_W=3 covers wrap/saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_fetch;

    typedef struct {
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults)
    logic        rst_n = 1'b0;
    logic        start = 1'b0, br = 1'b0, cf = 1'b0, ack = 1'b0;
    logic [9:0]  tgt = '0;
    logic [9:0]  pc;
    logic        running, done;
    logic [15:0] cnt;

    prog_fetch dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Start      (start),
        .BranchEn   (br),
        .CondFlag   (cf),
        .Ack        (ack),
        .TargetAddr (tgt),
        .ProgCtr    (pc),
        .Running    (running),
        .Done       (done),
        .CycleCnt   (cnt)
    );

    // Small instance for wrap and saturation
    logic        s_rst_n = 1'b0;
    logic        s_start = 1'b0, s_br = 1'b0, s_cf = 1'b0, s_ack = 1'b0;
    logic [3:0]  s_tgt = '0;
    logic [3:0]  s_pc;
    logic        s_running, s_done;
    logic [2:0]  s_cnt;

    prog_fetch #(.PC_W(4), .START_PC(0), .CNT_W(3)) dut_s (
        .Clk        (clk),
        .Reset      (s_rst_n),
        .Start      (s_start),
        .BranchEn   (s_br),
        .CondFlag   (s_cf),
        .Ack        (s_ack),
        .TargetAddr (s_tgt),
        .ProgCtr    (s_pc),
        .Running    (s_running),
        .Done       (s_done),
        .CycleCnt   (s_cnt)
    );

    // ---------------- monitors ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q_m.size() > 0) begin
                e = q_m.pop_front();
                checks++;
                if (pc !== e.pc || running !== e.run || done !== e.done || cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL main t=%0t got pc=%0d run=%b done=%b cnt=%0d expected pc=%0d run=%b done=%b cnt=%0d",
                             $time, pc, running, done, cnt, e.pc, e.run, e.done, e.cnt);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                checks++;
                if ({6'd0, s_pc} !== e.pc || s_running !== e.run || s_done !== e.done ||
                    {13'd0, s_cnt} !== e.cnt) begin
                    errors++;
                    $display("FAIL small t=%0t got pc=%0d run=%b done=%b cnt=%0d expected pc=%0d run=%b done=%b cnt=%0d",
                             $time, s_pc, s_running, s_done, s_cnt, e.pc, e.run, e.done, e.cnt);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_m(input logic [9:0] epc, input logic erun, input logic edone,
                          input logic [15:0] ecnt);
        exp_t e;
        e.pc = epc; e.run = erun; e.done = edone; e.cnt = ecnt;
        q_m.push_back(e);
    endtask

    // Drive inputs for the next edge and queue the state expected after it.
    task automatic cyc(input logic st, input logic b, input logic c, input logic a,
                       input logic [9:0] t, input logic [9:0] epc, input logic erun,
                       input logic edone, input logic [15:0] ecnt);
        @(negedge clk);
        start = st; br = b; cf = c; ack = a; tgt = t;
        push_m(epc, erun, edone, ecnt);
    endtask

    task automatic scyc(input logic st, input logic a, input logic [3:0] epc,
                        input logic erun, input logic edone, input logic [2:0] ecnt);
        exp_t e;
        @(negedge clk);
        s_start = st; s_ack = a;
        e.pc = {6'd0, epc}; e.run = erun; e.done = edone; e.cnt = {13'd0, ecnt};
        q_s.push_back(e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Start handshake: two cycles high stays in IDLE, low launches RUN
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0, 10'(i), 1, 0, 16'(i));
        // Branch not taken at pc=5
        cyc(0, 1, 0, 0, 10'd200, 10'd6, 1, 0, 16'd6);
        for (int i = 7; i <= 9; i++) cyc(0, 0, 0, 0, 0, 10'(i), 1, 0, 16'(i));
        // Abort at pc=9: IDLE, pc=0, counter holds 9
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd9);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Second run: branch taken at pc=5 to 200, then back to 7
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0, 10'(i), 1, 0, 16'(i));
        cyc(0, 1, 1, 0, 10'd200, 10'd200, 1, 0, 16'd6);
        cyc(0, 1, 1, 0, 10'd7, 10'd7, 1, 0, 16'd7);
        for (int i = 8; i <= 12; i++) cyc(0, 0, 0, 0, 0, 10'(i), 1, 0, 16'(i));
        // Ack together with taken branch at pc=12: Ack wins
        cyc(0, 1, 1, 1, 10'd99, 10'd12, 0, 1, 16'd13);
        // DONE ignores Ack/branch
        cyc(0, 1, 1, 0, 10'd99, 10'd12, 0, 1, 16'd13);
        cyc(0, 0, 0, 1, 10'd0, 10'd12, 0, 1, 16'd13);
        // Start pulse returns to IDLE then RUN from 0 with counter cleared
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'd13);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 37; i++) cyc(0, 0, 0, 0, 0, 10'(i), 1, 0, 16'(i));

        // Async reset mid-run at pc=37, observed before the next edge
        @(negedge clk);
        push_m(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Small instance: wrap 15 -> 0 and counter saturating at 7
        @(negedge clk);
        s_rst_n = 1'b1;
        scyc(1, 0, 0, 0, 0, 0);
        scyc(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 20; i++)
            scyc(0, 0, 4'(i % 16), 1, 0, (i > 7) ? 3'd7 : 3'(i));
        scyc(0, 1, 4'd4, 0, 1, 3'd7);

        // Drain
        repeat (3) @(posedge clk);
        #2;
        if (q_m.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL drain pending main=%0d small=%0d expected 0", q_m.size(), q_s.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
